// File: rtl/fifo_pkg.sv
// Shared constants and FSM encoding for the FIFO burst reader.
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH = 16;
  localparam int unsigned FIFO_DEPTH = 512;
  localparam int unsigned BURST_W    = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer holding FIFO read data until the stream consumer accepts it.
module fifo_rd_skid #(
  parameter int unsigned WIDTH = fifo_pkg::FIFO_WIDTH
) (
  input  logic             clk_b,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;

  // head is always the oldest entry; tail only holds data when occ==2
  always_ff @(posedge clk_b) begin
    if (rst) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= data_in;
          else             tail <= data_in;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head <= data_in;
          end else begin
            head <= tail;
            tail <= data_in;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_out = head;

endmodule

// File: rtl/fifo_reader.sv
// Reads a requested burst of words from a FIFO and presents them as a valid/ready stream.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
  parameter int unsigned BURST_W    = fifo_pkg::BURST_W
) (
  input  logic                  clk_b,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BURST_W-1:0]    burst_len,
  output logic                  ren_b,
  input  logic [FIFO_WIDTH-1:0] dout_b,
  input  logic                  empty,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic [BURST_W-1:0]    rd_count
);

  state_t             state;
  state_t             state_n;
  logic [BURST_W-1:0] burst_q;
  logic [BURST_W-1:0] issued;
  logic               inflight;
  logic [1:0]         occ;
  logic               pop;
  logic               last_pop;
  logic [2:0]         level;

  assign m_valid  = (occ != 2'd0);
  assign pop      = m_valid && m_ready;
  assign last_pop = pop && ((rd_count + BURST_W'(1)) == burst_q);
  // Words that will be buffered after this cycle if nothing new is read
  assign level    = 3'(occ) + 3'(inflight) - 3'(pop);

  always_comb begin
    state_n = state;
    ren_b   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = (burst_len == '0) ? DONE : RUN;
      end
      RUN: begin
        ren_b = !rst && !empty && (issued < burst_q) && (level < 3'd2);
        if (last_pop) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_b) begin
    if (rst) begin
      state    <= IDLE;
      burst_q  <= '0;
      issued   <= '0;
      rd_count <= '0;
      inflight <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      inflight <= ren_b;
      busy     <= (state_n != IDLE);
      done     <= (state_n == DONE);
      if ((state == IDLE) && start) begin
        burst_q  <= burst_len;
        issued   <= '0;
        rd_count <= '0;
      end else begin
        if (ren_b) issued   <= issued + BURST_W'(1);
        if (pop)   rd_count <= rd_count + BURST_W'(1);
      end
    end
  end

  fifo_rd_skid #(
    .WIDTH(FIFO_WIDTH)
  ) u_skid (
    .clk_b    (clk_b),
    .rst      (rst),
    .push     (inflight),
    .pop      (pop),
    .data_in  (dout_b),
    .data_out (m_data),
    .occ      (occ)
  );

endmodule
